pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of architectural registers (ID width 3).
REQ-002 SHALL have parameter WB_DIST, default 3, number of cycles from ID issue until the RF write has landed.
REQ-003 SHALL have parameter FLAG_DIST, default 1, number of cycles from ID issue until C/Z are updated.
REQ-004 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port: id_valid  in  1  PR1 holds a real instruction.
REQ-007 SHALL have ports: id_rs1, id_rs2  in  3 each  source register IDs of the instruction in ID.
REQ-008 SHALL have ports: id_use_rs1, id_use_rs2  in  1 each  the corresponding source is read.
REQ-009 SHALL have ports: id_rd  in  3  destination ID; id_writes_rd  in  1  RF write enable of the ID instruction.
REQ-010 SHALL have ports: id_sets_flags  in  1  instruction updates C/Z; id_uses_flags  in  1  instruction reads C/Z (conditional branch, add-with-carry).
REQ-011 SHALL have port: id_redirect  in  1  ID instruction changes PC (taken branch, jump, call, return).
REQ-012 SHALL have port: stall  out  1  hold the PC and PR1 (PC ld=0, PR1 ld=0).
REQ-013 SHALL have port: bubble  out  1  load PR2 with all control enables zeroed.
REQ-014 SHALL have port: flush  out  1  load PR1 with a NOP (id_valid=0 next cycle).
REQ-015 SHALL have port: pc_redirect_en  out  1  select the non-plus1 PC source this cycle.
REQ-016 SHALL have port: stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 SHALL keep one 2-bit busy counter per register and one flag counter.
REQ-018 SHALL define issue = id_valid & ~stall.
REQ-019 SHALL set busy[id_rd] to WB_DIST on issue with id_writes_rd; otherwise each nonzero counter SHALL decrement by 1 per cycle; the set SHALL take priority over the decrement for the same register.
REQ-020 SHALL set the flag counter to FLAG_DIST on issue with id_sets_flags; otherwise the flag counter SHALL decrement while nonzero.
REQ-021 SHALL assert stall combinationally when id_valid and any of: (id_use_rs1 & busy[id_rs1]!=0), (id_use_rs2 & busy[id_rs2]!=0), (id_uses_flags & flagcnt!=0).
REQ-022 SHALL make bubble equal to stall (the held ID instruction is not duplicated into EX).
REQ-023 SHALL implement an FSM with states RUN, STALL and FLUSH, with transitions: RUN->STALL when stall=1; STALL->RUN when stall=0; RUN/STALL->FLUSH on issue with id_redirect; FLUSH->RUN unconditionally after 1 cycle.
REQ-024 SHALL assert pc_redirect_en and flush in the same cycle the redirecting instruction issues; a redirect on a stalled instruction SHALL be ignored until it issues.
REQ-025 SHALL, in FLUSH, treat PR1 as invalid: no stall and no redirect is evaluated; only counters decrement.
REQ-026 SHALL ensure that WAW (same rd reissued) reloads the counter to WB_DIST and never stalls on its own.
REQ-027 SHALL increment stall_count every cycle stall=1 and hold it at 16'hFFFF once reached.
REQ-028 SHALL not stall when id_valid=0, regardless of the source fields.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, clear all busy counters and the flag counter, set FSM=RUN and stall_count=0.
REQ-030 SHALL hold stall, bubble, flush and pc_redirect_en at 0 during the cycle rst=1, regardless of inputs.
REQ-031 SHALL, on reset asserted mid-stall or mid-flush, discard all pending hazards; the first instruction after reset issues without stall.

Verification
REQ-032 SHALL verify: issue ADD R3 (writes R3) at cycle 0, then an instruction reading rs1=R3 in ID at cycle 1 -> stall=bubble=1 for cycles 1-3, issue at cycle 4, stall_count=3.
REQ-033 SHALL verify: flag-setting SUB issues at cycle 0, then a conditional branch with id_uses_flags=1 and id_redirect=1 at cycle 1 -> 1 stall cycle; at cycle 2 pc_redirect_en=flush=1; cycle 3 FSM=FLUSH with stall=0.
REQ-034 SHALL verify: independent instructions (sources never busy) for 20 cycles -> stall never asserted, stall_count=0.
REQ-035 SHALL verify: writers to R1 at cycles 0 and 1, reader of R1 at cycle 2 -> stall cycles 2-4 (counter reloaded by second writer), issue at cycle 5.
REQ-036 SHALL verify: rst pulsed at cycle 2 of a 3-cycle stall -> stall=0 in the reset cycle; the same reader issues on the first post-reset cycle.
REQ-037 SHALL verify: stall_count preloaded near saturation via 65540 stall cycles -> value remains 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: in-order pipeline interlock; per-register and flag scoreboards drive stall/bubble/flush/redirect.
// Latency: stall, bubble, flush and pc_redirect_en are combinational from ID; scoreboards update on the next edge.
// Backpressure: stall holds PC/PR1 and bubbles PR2 until the sources clear; a redirect is honoured only on issue.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_valid, id_rs1/2, id_use_rs1/2 instruction in ID and its register sources
//   id_rd, id_writes_rd              destination register and its write enable
//   id_sets_flags, id_uses_flags     C/Z producer / consumer
//   id_redirect                      instruction changes the PC
//   stall, bubble, flush, pc_redirect_en  pipeline controls
//   stall_count                      saturating count of stall cycles
module pipeline_hazard_ctrl #(
    parameter int NUM_REGS  = 8,
    parameter int WB_DIST   = 3,
    parameter int FLAG_DIST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs1,
    input  logic [2:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [2:0]  id_rd,
    input  logic        id_writes_rd,
    input  logic        id_sets_flags,
    input  logic        id_uses_flags,
    input  logic        id_redirect,
    output logic        stall,
    output logic        bubble,
    output logic        flush,
    output logic        pc_redirect_en,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] WB_LOAD   = 2'(WB_DIST);
    localparam logic [1:0] FLAG_LOAD = 2'(FLAG_DIST);

    state_t     state;
    logic [1:0] busy [NUM_REGS];
    logic [1:0] flag_cnt;

    logic eff_valid;
    logic hazard;
    logic issue;
    logic redirect;

    // In FLUSH the instruction in PR1 is the fetch-shadow slot and is treated
    // as a NOP; during reset nothing is allowed to stall or redirect.
    always_comb begin
        eff_valid = id_valid & ~rst & (state != ST_FLUSH);
        hazard    = (id_use_rs1    & (busy[id_rs1] != 2'd0)) |
                    (id_use_rs2    & (busy[id_rs2] != 2'd0)) |
                    (id_uses_flags & (flag_cnt     != 2'd0));
        stall          = eff_valid & hazard;
        bubble         = stall;
        issue          = eff_valid & ~hazard;
        redirect       = issue & id_redirect;
        flush          = redirect;
        pc_redirect_en = redirect;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            flag_cnt    <= 2'd0;
            stall_count <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                busy[i] <= 2'd0;
            end
        end else begin
            // A new writer reloads its counter, which also covers WAW reissue.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (issue && id_writes_rd && (int'(id_rd) == i)) begin
                    busy[i] <= WB_LOAD;
                end else if (busy[i] != 2'd0) begin
                    busy[i] <= busy[i] - 2'd1;
                end
            end

            if (issue && id_sets_flags) begin
                flag_cnt <= FLAG_LOAD;
            end else if (flag_cnt != 2'd0) begin
                flag_cnt <= flag_cnt - 2'd1;
            end

            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end

            case (state)
                ST_RUN, ST_STALL: begin
                    if (redirect) begin
                        state <= ST_FLUSH;
                    end else if (stall) begin
                        state <= ST_STALL;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_writes_rd;
    logic        id_sets_flags, id_uses_flags, id_redirect;
    logic        stall, bubble, flush, pc_redirect_en;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_writes_rd   (id_writes_rd),
        .id_sets_flags  (id_sets_flags),
        .id_uses_flags  (id_uses_flags),
        .id_redirect    (id_redirect),
        .stall          (stall),
        .bubble         (bubble),
        .flush          (flush),
        .pc_redirect_en (pc_redirect_en),
        .stall_count    (stall_count)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        u1;
        logic        u2;
        logic [2:0]  rd;
        logic        wr;
        logic        sets;
        logic        uses;
        logic        redir;
        logic        e_stall;
        logic        e_flush;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic v, input int s1, input int s2,
                                input logic u1, input logic u2, input int d, input logic w,
                                input logic st, input logic us, input logic rd_, input logic es,
                                input logic ef, input int ec);
        vec_t x;
        x.rst = r; x.vld = v; x.rs1 = 3'(s1); x.rs2 = 3'(s2); x.u1 = u1; x.u2 = u2;
        x.rd = 3'(d); x.wr = w; x.sets = st; x.uses = us; x.redir = rd_;
        x.e_stall = es; x.e_flush = ef; x.e_cnt = 16'(ec);
        return x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; id_valid = x.vld; id_rs1 = x.rs1; id_rs2 = x.rs2;
        id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_rd = x.rd; id_writes_rd = x.wr;
        id_sets_flags = x.sets; id_uses_flags = x.uses; id_redirect = x.redir;
    endtask

    task automatic do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_stall;
        int cycles;
        vec_t x;

        // Each row is one cycle; e_cnt is the count of stall cycles in earlier rows since reset.
        //           rst v  rs1 rs2 u1 u2 rd wr st us rdr  stall flush cnt
        vecs.push_back(mk(1, 1, 3, 3, 1, 1, 3, 1, 1, 1, 1,  0, 0, 0)); // reset overrides all
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0)); // ADD R3
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0)); // reader R3
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1));
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 2));
        vecs.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3)); // issues
        vecs.push_back(mk(0, 0, 3, 3, 1, 1, 0, 0, 0, 1, 1,  0, 0, 3)); // invalid never stalls
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,  0, 0, 3)); // SUB sets flags, R5
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  1, 0, 3)); // branch stalled, no redirect
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 1, 4)); // branch issues, redirect
        vecs.push_back(mk(0, 1, 5, 0, 1, 0, 6, 1, 1, 1, 1,  0, 0, 4)); // FLUSH: PR1 ignored
        vecs.push_back(mk(0, 1, 6, 6, 1, 1, 0, 0, 0, 1, 0,  0, 0, 4)); // flush slot set nothing
        vecs.push_back(mk(0, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 4)); // writer R1
        vecs.push_back(mk(0, 1, 2, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 4)); // WAW writer R1
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 4)); // reader R1
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 5));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  1, 0, 6));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 7)); // issues
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  0, 0, 7)); // writer R4
        vecs.push_back(mk(0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0,  1, 0, 7)); // reader R4 stalls
        vecs.push_back(mk(1, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0,  0, 0, 8)); // reset mid-stall
        vecs.push_back(mk(0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0)); // issues right away
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0)); // jump
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0)); // reset mid-flush
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0)); // back in RUN
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0));

        do_reset();
        foreach (vecs[i]) begin
            x = vecs[i];
            drive(x);
            @(negedge clk);
            check($sformatf("row%0d stall", i), int'(stall), int'(x.e_stall));
            check($sformatf("row%0d bubble", i), int'(bubble), int'(x.e_stall));
            check($sformatf("row%0d flush", i), int'(flush), int'(x.e_flush));
            check($sformatf("row%0d pc_redirect_en", i), int'(pc_redirect_en), int'(x.e_flush));
            check($sformatf("row%0d stall_count", i), int'(stall_count), int'(x.e_cnt));
            @(posedge clk);
            #1;
        end

        // Independent stream: each source was last written 4 cycles earlier.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(mk(0, 1, (i + 4) % 8, (i + 4) % 8, 1, 1, i % 8, 1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            check($sformatf("indep%0d stall", i), int'(stall), 0);
            @(posedge clk);
            #1;
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("indep stall_count", int'(stall_count), 0);
        @(posedge clk);
        #1;

        // Self-dependent R1 <- R1: issue, 3 stalls, repeat, until saturation.
        do_reset();
        drive(mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        n_stall = 0;
        cycles  = 0;
        while (n_stall < 65540 && cycles < 95000) begin
            @(negedge clk);
            if (n_stall >= 65530) begin
                check($sformatf("sat n=%0d", n_stall), int'(stall_count),
                      (n_stall > 65535) ? 65535 : n_stall);
            end
            if (stall) n_stall++;
            cycles++;
            @(posedge clk);
            #1;
        end
        check("sat stall cycles reached", (n_stall >= 65540) ? 1 : 0, 1);
        @(negedge clk);
        check("sat final stall_count", int'(stall_count), 65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
